// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory and
// buffers one instruction for the decoder, with stall, redirect and drain handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  fn,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 6;
  localparam logic [XLEN-1:0] WORD = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] addr_inc;

  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign addr_inc = addr_q + WORD;

  // Next-state and registered-output logic; redirect always wins.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        state_d = FETCH;
        req_d   = 1'b1;
        if (redirect) begin
          pc_d   = redir_pc;
          addr_d = redir_pc;
        end else begin
          addr_d = pc_q;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redir_pc;
          // An acked request is done, so reissue at once; otherwise wait it out.
          if (imem_ack) addr_d  = redir_pc;
          else          state_d = DRAIN;
        end else if (imem_ack) begin
          instr_d    = imem_data;
          pc_out_d   = addr_q;
          pc_plus4_d = addr_inc;
          valid_d    = 1'b1;
          pc_d       = addr_inc;
          req_d      = 1'b0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redir_pc;
          req_d   = 1'b1;
          addr_d  = redir_pc;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d = redir_pc;
        end else if (imem_ack) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus4_q <= WORD;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign valid     = valid_q;
  assign instr     = instr_q;
  assign op        = instr_q[XLEN-1:XLEN-OP_W];
  assign fn        = instr_q[OP_W-1:0];
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait fetch, stall, redirects, drain,
// PC wrap (second instance) and asynchronous reset mid-operation.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ack, stall, redirect;
  logic [31:0] imem_data, redirect_pc;
  logic        imem_req, valid;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4;
  logic [5:0]  op, fn;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc_out, w_pc_plus4;
  logic [5:0]  w_op, w_fn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h00000000)) u_dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid(valid), .instr(instr), .op(op), .fn(fn),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_data(32'h03E00008),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h00000000),
    .valid(w_valid), .instr(w_instr), .op(w_op), .fn(w_fn),
    .pc_out(w_pc_out), .pc_plus4(w_pc_plus4)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; return at the falling edge, where checks and new inputs happen.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".req"},   32'(imem_req),  32'h0);
    check({tag, ".addr"},  imem_addr,      32'h0);
    check({tag, ".valid"}, 32'(valid),     32'h0);
    check({tag, ".instr"}, instr,          32'h0);
    check({tag, ".op"},    32'(op),        32'h0);
    check({tag, ".fn"},    32'(fn),        32'h0);
    check({tag, ".pc"},    pc_out,         32'h0);
    check({tag, ".pc4"},   pc_plus4,       32'h4);
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b1; imem_data = 32'h20080005;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    check_reset_vals("rst");
    check("wrap_rst.addr", w_addr, 32'hFFFFFFFC);
    check("wrap_rst.pc4",  w_pc_plus4, 32'h4);

    // Zero-wait fetch at address 0
    reset = 1'b1;
    tick();
    check("f0.req",  32'(imem_req), 32'h1);
    check("f0.addr", imem_addr, 32'h0);
    check("f0.valid", 32'(valid), 32'h0);
    check("wrap_f0.addr", w_addr, 32'hFFFFFFFC);
    stall = 1'b1;
    tick();
    check("d0.valid", 32'(valid), 32'h1);
    check("d0.op",    32'(op), 32'h08);
    check("d0.fn",    32'(fn), 32'h05);
    check("d0.instr", instr, 32'h20080005);
    check("d0.pc",    pc_out, 32'h0);
    check("d0.pc4",   pc_plus4, 32'h4);
    check("d0.req",   32'(imem_req), 32'h0);
    check("wrap_d0.valid", 32'(w_valid), 32'h1);
    check("wrap_d0.pc",    w_pc_out, 32'hFFFFFFFC);
    check("wrap_d0.pc4",   w_pc_plus4, 32'h0);

    // Stall for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.valid", 32'(valid), 32'h1);
      check("stall.instr", instr, 32'h20080005);
      check("stall.pc",    pc_out, 32'h0);
      check("stall.req",   32'(imem_req), 32'h0);
      if (i == 0) begin
        check("wrap_f1.req",  32'(w_req), 32'h1);
        check("wrap_f1.addr", w_addr, 32'h0);
      end
    end
    stall = 1'b0;
    imem_data = 32'h8C090010;
    tick();
    check("f1.valid", 32'(valid), 32'h0);
    check("f1.req",   32'(imem_req), 32'h1);
    check("f1.addr",  imem_addr, 32'h4);
    stall = 1'b1;
    tick();
    check("d1.valid", 32'(valid), 32'h1);
    check("d1.op",    32'(op), 32'h23);
    check("d1.fn",    32'(fn), 32'h10);
    check("d1.pc",    pc_out, 32'h4);
    check("d1.pc4",   pc_plus4, 32'h8);

    // Redirect in HOLD (stall also high) to an unaligned target
    redirect = 1'b1; redirect_pc = 32'h00000103;
    tick();
    check("rh.valid", 32'(valid), 32'h0);
    check("rh.req",   32'(imem_req), 32'h1);
    check("rh.addr",  imem_addr, 32'h100);

    // Redirect in FETCH coinciding with ack: data discarded, refetch at 0x8
    stall = 1'b0; redirect_pc = 32'h00000008; imem_data = 32'hDEADBEEF;
    tick();
    check("rf.valid", 32'(valid), 32'h0);
    check("rf.req",   32'(imem_req), 32'h1);
    check("rf.addr",  imem_addr, 32'h8);
    check("rf.instr", instr, 32'h8C090010);

    // Redirect to 0x40 while request to 0x8 is outstanding
    redirect_pc = 32'h00000040; imem_ack = 1'b0;
    tick();
    redirect = 1'b0;
    check("dr0.addr",  imem_addr, 32'h8);
    check("dr0.req",   32'(imem_req), 32'h1);
    check("dr0.valid", 32'(valid), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drw.addr",  imem_addr, 32'h8);
      check("drw.req",   32'(imem_req), 32'h1);
      check("drw.valid", 32'(valid), 32'h0);
    end
    imem_ack = 1'b1; imem_data = 32'hBAD0BAD0;
    tick();
    imem_ack = 1'b0;
    check("dr1.addr",  imem_addr, 32'h40);
    check("dr1.req",   32'(imem_req), 32'h1);
    check("dr1.valid", 32'(valid), 32'h0);
    check("dr1.instr", instr, 32'h8C090010);
    tick();
    check("dr2.valid", 32'(valid), 32'h0);
    check("dr2.addr",  imem_addr, 32'h40);

    // Enter DRAIN again, then assert reset asynchronously mid-cycle
    redirect = 1'b1; redirect_pc = 32'h00000080;
    tick();
    redirect = 1'b0;
    check("dr3.addr", imem_addr, 32'h40);
    check("dr3.req",  32'(imem_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    reset = 1'b1;
    imem_ack = 1'b1; imem_data = 32'h20080005;
    tick();
    check("post.req",  32'(imem_req), 32'h1);
    check("post.addr", imem_addr, 32'h0);
    check("wrap_post.addr", w_addr, 32'hFFFFFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
